scan_display: RTL and testbench
===============================

SCAN_DISPLAY -- requirements
Module: scan_display

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed seven-segment digits; legal values are 4 to 8.
REQ-002 Parameter TIME_W, default 32: width of t_react in ms.
REQ-003 Parameter SCAN_DIV, default 4: clocks per digit slot; legal values are 1 or more.
REQ-004 Parameter MIN_VALID, default 100: minimum legal reaction time in ms.
REQ-005 Parameter LZ_KEEP, default 3: number of low digits never blanked by leading-zero suppression.
REQ-006 Port clock, input, 1: sole clock; all logic is on the rising edge.
REQ-007 Port reset, input, 1: synchronous, active-low reset.
REQ-008 Port start, input, 1: test enable; low returns the block to IDLE.
REQ-009 Port random_finish, input, 1: random wait has elapsed.
REQ-010 Port react, input, 1: user button.
REQ-011 Port react_exceed, input, 1: reaction timeout.
REQ-012 Port t_react, input, TIME_W: reaction time in ms, binary.
REQ-013 Port show_best, input, 1: request to display the best time while in IDLE.
REQ-014 Port seg, output, 7: active-low segments, seg[6]=a through seg[0]=g.
REQ-015 Port an, output, DIGITS: active-low digit enables; an[DIGITS-1] is the leftmost digit.
REQ-016 Port busy, output, 1: high while state is CONV.
REQ-017 Port new_best, output, 1: one-cycle pulse when the best time is updated.

Function
REQ-018 Glyph encodings: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, dash=1111110, blank=1111111, F=0111000, A=0001000, I=1001111, L=1110001.
REQ-019 Scan: a prescaler counts 0 to SCAN_DIV-1; on wrap, the digit index steps DIGITS-1, DIGITS-2, ... 0, then back to DIGITS-1.
REQ-020 Scan timing: exactly one an bit is low at any time; seg and an update in the same cycle and are registered, with 1-cycle latency from index to output.
REQ-021 FSM states: IDLE, ARMED, GO, CONV, SHOW, FAIL.
REQ-022 Priority: start=0 in any state moves to IDLE on the next cycle; this aborts CONV and leaves best unchanged.
REQ-023 IDLE, start=1: go to ARMED.
REQ-024 ARMED: react=1 goes to FAIL, including when random_finish=1 in the same cycle; random_finish=1 with react=0 goes to GO.
REQ-025 GO, react_exceed=1: go to FAIL, even if react=1 in the same cycle.
REQ-026 GO, react=1 and t_react < MIN_VALID: go to FAIL.
REQ-027 GO, react=1 and t_react >= MIN_VALID: latch t_react and go to CONV.
REQ-028 CONV: iterative binary-to-BCD (double-dabble, one bit per clock) lasting exactly TIME_W cycles, then go to SHOW.
REQ-029 CONV saturation: a latched value >= 10^DIGITS saturates to all 9s.
REQ-030 SHOW and FAIL: hold until start=0.
REQ-031 Display content per state:
  - IDLE: all digits blank; if show_best=1 and best_valid=1, show best.
  - ARMED: all digits dash.
  - GO and CONV: all digits "1".
  - SHOW: BCD result.
  - FAIL: "FAIL" on the leftmost four digits, remaining digits blank.
REQ-032 Leading-zero suppression: in SHOW and best display, zero digits above the highest nonzero digit and at or above position LZ_KEEP show blank.
REQ-033 Best-time update: on the CONV-to-SHOW transition, if best_valid=0 or result < best, load best (BCD), set best_valid, and pulse new_best for one cycle.
REQ-034 Equal time: a result equal to best does not update best and does not pulse new_best.
REQ-035 Input sampling: inputs are sampled every clock, with no edge detection; a react held from ARMED into GO is already consumed by the transition to FAIL.

Reset
REQ-036 reset=0 at a rising edge sets state=IDLE, prescaler=0, digit index=DIGITS-1, and clears best and best_valid.
REQ-037 While reset is low: seg=1111111, an=all ones, busy=0, new_best=0.
REQ-038 First cycle after reset is released: an[DIGITS-1] is low.
REQ-039 Reset during CONV aborts the conversion with no best update.

Verification
REQ-040 DIGITS=4, SCAN_DIV=2: hold start=0 -> an cycles 0111, 1011, 1101, 1110, each for 2 clocks, with seg=1111111.
REQ-041 start=1, then react=1 before random_finish -> FAIL; an=0111 with seg=0111000, then 1011/0001000, 1101/1001111, 1110/1110001.
REQ-042 random_finish=1, react=1 with t_react=347 -> busy high for exactly 32 cycles, then digits show blank,3,4,7 and new_best pulses once.
REQ-043 Second run with t_react=512 -> shows 5,1,2 and new_best stays 0; then start=0 with show_best=1 -> IDLE shows blank,3,4,7.
REQ-044 In GO, react=1 with t_react=99 -> FAIL; in GO, react_exceed=1 and react=1 together -> FAIL.
REQ-045 t_react=12345 with DIGITS=4 -> shows 9,9,9,9; reset=0 asserted mid-CONV -> IDLE with best_valid=0.

Source files
------------

// File: rtl/scan_display_if.sv
// ============================================================================
// Module      : scan_display_if
// Description : Control inputs and display outputs of the reaction-timer
//               scanned seven-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface scan_display_if #(
    parameter int DIGITS = 4,
    parameter int TIME_W = 32
);
    logic              start;
    logic              random_finish;
    logic              react;
    logic              react_exceed;
    logic [TIME_W-1:0] t_react;
    logic              show_best;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;
    logic              busy;
    logic              new_best;

    modport master (
        output start, random_finish, react, react_exceed, t_react, show_best,
        input  seg, an, busy, new_best
    );

    modport slave (
        input  start, random_finish, react, react_exceed, t_react, show_best,
        output seg, an, busy, new_best
    );
endinterface

`default_nettype wire

// File: rtl/scan_display.sv
// ============================================================================
// Module      : scan_display
// Description : Reaction-timer controller with serial binary-to-BCD conversion,
//               best-time tracking and a multiplexed seven-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_display #(
    parameter int DIGITS    = 4,
    parameter int TIME_W    = 32,
    parameter int SCAN_DIV  = 4,
    parameter int MIN_VALID = 100,
    parameter int LZ_KEEP   = 3
) (
    input logic         clock,
    input logic         reset,
    scan_display_if.slave bus
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_IDX_W = $clog2(DIGITS);
    localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_CNT_W = $clog2(TIME_W + 1);

    localparam logic [63:0]        c_SAT_LIMIT  = 64'(10 ** DIGITS);
    localparam logic [c_BCD_W-1:0] c_ALL_NINES  = {DIGITS{4'h9}};
    localparam logic [6:0]         c_SEG_BLANK  = 7'b1111111;
    localparam logic [6:0]         c_SEG_DASH   = 7'b1111110;
    localparam logic [6:0]         c_SEG_ONE    = 7'b1001111;
    localparam logic [6:0]         c_SEG_F      = 7'b0111000;
    localparam logic [6:0]         c_SEG_A      = 7'b0001000;
    localparam logic [6:0]         c_SEG_I      = 7'b1001111;
    localparam logic [6:0]         c_SEG_L      = 7'b1110001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_GO    = 3'd2,
        S_CONV  = 3'd3,
        S_SHOW  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_conv_done;
    logic                 w_latch;

    logic [TIME_W-1:0]    r_bin;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_sat;
    logic [c_BCD_W-1:0]   r_best;
    logic                 r_best_valid;
    logic                 r_new_best;

    logic [c_BCD_W-1:0]   w_adj;
    logic [c_BCD_W-1:0]   w_bcd_shift;
    logic [c_BCD_W-1:0]   w_result;

    logic [c_PRE_W-1:0]   r_pre;
    logic [c_IDX_W-1:0]   r_idx;
    logic [6:0]           r_seg;
    logic [DIGITS-1:0]    r_an;

    logic [31:0]          w_idx32;
    logic [c_BCD_W-1:0]   w_src;
    logic                 w_show_num;
    logic                 w_upper_zero;
    logic [3:0]           w_digit;
    logic [6:0]           w_seg;

    function automatic logic [6:0] f_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'b0000001;
            4'd1:    g = 7'b1001111;
            4'd2:    g = 7'b0010010;
            4'd3:    g = 7'b0000110;
            4'd4:    g = 7'b1001100;
            4'd5:    g = 7'b0100100;
            4'd6:    g = 7'b0100000;
            4'd7:    g = 7'b0001111;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0000100;
            default: g = c_SEG_BLANK;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_conv_done  = 1'b0;
        if (!bus.start) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_ARMED;
                S_ARMED: begin
                    // A premature press wins even if the wait ends this cycle.
                    if (bus.react) begin
                        w_state_next = S_FAIL;
                    end else if (bus.random_finish) begin
                        w_state_next = S_GO;
                    end
                end
                S_GO: begin
                    if (bus.react_exceed) begin
                        w_state_next = S_FAIL;
                    end else if (bus.react) begin
                        if (bus.t_react < TIME_W'(MIN_VALID)) begin
                            w_state_next = S_FAIL;
                        end else begin
                            w_state_next = S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    if (r_cnt == c_CNT_W'(TIME_W - 1)) begin
                        w_state_next = S_SHOW;
                        w_conv_done  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_latch = (r_state == S_GO) && (w_state_next == S_CONV);

    // ------------------------------------------------------------------
    // Double-dabble step: add 3 to digits >= 5, then shift in the next bit
    // ------------------------------------------------------------------
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
        w_bcd_shift = c_BCD_W'({w_adj, r_bin[TIME_W-1]});
        w_result    = r_sat ? c_ALL_NINES : w_bcd_shift;
    end

    // BCD ordering equals numeric ordering, so best compares digit-wise.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bin        <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_sat        <= 1'b0;
            r_best       <= '0;
            r_best_valid <= 1'b0;
            r_new_best   <= 1'b0;
        end else begin
            r_new_best <= 1'b0;
            if (w_latch) begin
                r_bin <= bus.t_react;
                r_bcd <= '0;
                r_cnt <= '0;
                r_sat <= (64'(bus.t_react) >= c_SAT_LIMIT);
            end else if (r_state == S_CONV) begin
                r_bin <= {r_bin[TIME_W-2:0], 1'b0};
                r_bcd <= w_conv_done ? w_result : w_bcd_shift;
                r_cnt <= r_cnt + 1'b1;
                if (w_conv_done && (!r_best_valid || (w_result < r_best))) begin
                    r_best       <= w_result;
                    r_best_valid <= 1'b1;
                    r_new_best   <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit scanner: index walks from the leftmost digit down to 0
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pre <= '0;
            r_idx <= c_IDX_W'(DIGITS - 1);
        end else if (r_pre == c_PRE_W'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= (r_idx == '0) ? c_IDX_W'(DIGITS - 1) : r_idx - 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Glyph selection for the digit currently addressed
    // ------------------------------------------------------------------
    always_comb begin
        w_idx32      = 32'(r_idx);
        w_src        = r_bcd;
        w_show_num   = 1'b0;
        w_seg        = c_SEG_BLANK;
        w_upper_zero = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (bus.show_best && r_best_valid) begin
                    w_show_num = 1'b1;
                    w_src      = r_best;
                end
            end
            S_ARMED:      w_seg = c_SEG_DASH;
            S_GO, S_CONV: w_seg = c_SEG_ONE;
            S_SHOW:       w_show_num = 1'b1;
            S_FAIL: begin
                if (r_idx == c_IDX_W'(DIGITS - 1)) begin
                    w_seg = c_SEG_F;
                end else if (r_idx == c_IDX_W'(DIGITS - 2)) begin
                    w_seg = c_SEG_A;
                end else if (r_idx == c_IDX_W'(DIGITS - 3)) begin
                    w_seg = c_SEG_I;
                end else if (r_idx == c_IDX_W'(DIGITS - 4)) begin
                    w_seg = c_SEG_L;
                end
            end
            default: ;
        endcase

        w_digit = w_src[w_idx32*4 +: 4];
        for (int d = 0; d < DIGITS; d++) begin
            if ((d >= w_idx32) && (w_src[4*d +: 4] != 4'd0)) begin
                w_upper_zero = 1'b0;
            end
        end

        if (w_show_num) begin
            if (w_upper_zero && (w_idx32 >= 32'(LZ_KEEP))) begin
                w_seg = c_SEG_BLANK;
            end else begin
                w_seg = f_glyph(w_digit);
            end
        end
    end

    // Reset preloads the leftmost enable so it is lit on the first free cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_seg <= c_SEG_BLANK;
            r_an  <= ~(DIGITS'(1) << (DIGITS - 1));
        end else begin
            r_seg <= w_seg;
            r_an  <= ~(DIGITS'(1) << r_idx);
        end
    end

    assign bus.seg      = reset ? r_seg : c_SEG_BLANK;
    assign bus.an       = reset ? r_an  : '1;
    assign bus.busy     = reset && (r_state == S_CONV);
    assign bus.new_best = reset && r_new_best;

endmodule

`default_nettype wire

// File: tb/tb_scan_display.sv
// ============================================================================
// Module      : tb_scan_display
// Description : Self-checking bench for scan_display (DIGITS=4, SCAN_DIV=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_display;

    localparam int c_DIGITS = 4;
    localparam int c_TIME_W = 32;

    logic clock;
    logic reset;

    int checks;
    int errors;

    int m_best;
    bit m_valid;

    scan_display_if #(.DIGITS(c_DIGITS), .TIME_W(c_TIME_W)) bus ();

    scan_display #(
        .DIGITS(c_DIGITS), .TIME_W(c_TIME_W), .SCAN_DIV(2),
        .MIN_VALID(100), .LZ_KEEP(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int t;
        int mode;       // 0 normal, 1 early press, 2 timeout with press
        bit exp_fail;
        int exp_nb;
        int exp_shown;
    } vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected four-digit picture of a number, position p at bits [p*7 +: 7]
    function automatic logic [27:0] exp_number(input int v);
        logic [27:0] r;
        int s;
        int pw;
        s  = (v > 9999) ? 9999 : v;
        pw = 1;
        r  = '1;
        for (int p = 0; p < 4; p++) begin
            if (p >= 3 && (s / pw) == 0) r[p*7 +: 7] = 7'b1111111;
            else                         r[p*7 +: 7] = glyph((s / pw) % 10);
            pw = pw * 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] exp_fill(input logic [6:0] g);
        return {g, g, g, g};
    endfunction

    function automatic logic [27:0] exp_fail_pic();
        return {7'b0111000, 7'b0001000, 7'b1001111, 7'b1110001};
    endfunction

    // Reference model of one attempt; updates the tracked best time.
    task automatic model(input int t, input int mode, output bit fail,
                         output int shown, output int nb);
        fail  = (mode != 0) || (t < 100);
        shown = (t > 9999) ? 9999 : t;
        nb    = 0;
        if (!fail && (!m_valid || shown < m_best)) begin
            m_best  = shown;
            m_valid = 1'b1;
            nb      = 1;
        end
    endtask

    // Watch one full scan and collect the glyph seen on each position.
    task automatic capture(output logic [27:0] disp);
        logic [3:0] seen;
        logic [3:0] m;
        seen = '0;
        disp = {4{7'b1010101}};
        for (int i = 0; i < 24 && seen != 4'hF; i++) begin
            for (int p = 0; p < 4; p++) begin
                m = 4'b0001 << p;
                if (bus.an == ~m) begin
                    disp[p*7 +: 7] = bus.seg;
                    seen[p] = 1'b1;
                end
            end
            tick();
        end
    endtask

    task automatic go_idle();
        bus.start = 0; bus.react = 0; bus.random_finish = 0;
        bus.react_exceed = 0; bus.show_best = 0;
        tick(); tick();
    endtask

    task automatic run(input int t, input int mode, input bit early_rf,
                       output int busy_n, output int nb_n, output logic [27:0] disp);
        go_idle();
        bus.start = 1;
        tick();
        if (mode == 1) begin
            bus.react = 1; bus.random_finish = early_rf;
            tick();
            bus.react = 0; bus.random_finish = 0;
        end else begin
            bus.random_finish = 1;
            tick();
            bus.random_finish = 0;
            bus.t_react = c_TIME_W'(t);
            bus.react = 1;
            bus.react_exceed = (mode == 2);
            tick();
            bus.react = 0; bus.react_exceed = 0;
        end
        busy_n = 0;
        nb_n   = 0;
        for (int i = 0; i < 48; i++) begin
            if (bus.busy)     busy_n++;
            if (bus.new_best) nb_n++;
            tick();
        end
        capture(disp);
    endtask

    initial begin
        vec_t vecs[10];
        logic [27:0] disp;
        logic [3:0] m;
        int busy_n, nb_n, shown, nb, exp_busy;
        bit fail;
        int mode, r;
        int t;

        checks = 0; errors = 0; m_best = 0; m_valid = 0;
        vecs[0] = '{347,   0, 0, 1, 347};
        vecs[1] = '{512,   0, 0, 0, 512};
        vecs[2] = '{99,    0, 1, 0, 0};
        vecs[3] = '{0,     1, 1, 0, 0};
        vecs[4] = '{250,   2, 1, 0, 0};
        vecs[5] = '{12345, 0, 0, 0, 9999};
        vecs[6] = '{100,   0, 0, 1, 100};
        vecs[7] = '{100,   0, 0, 0, 100};
        vecs[8] = '{9999,  0, 0, 0, 9999};
        vecs[9] = '{10000, 0, 0, 0, 9999};

        reset = 0;
        bus.start = 0; bus.random_finish = 0; bus.react = 0;
        bus.react_exceed = 0; bus.t_react = '0; bus.show_best = 0;
        tick(); tick(); tick();
        check("reset_outputs", {bus.seg, bus.an, bus.busy, bus.new_best},
              {7'b1111111, 4'b1111, 1'b0, 1'b0});

        reset = 1;
        #1;
        check("first_an", bus.an, 4'b0111);

        // Scan order with start held low
        for (int i = 0; i < 10 && bus.an == 4'b0111; i++) tick();
        for (int k = 0; k < 8; k++) begin
            m = 4'b0001 << ((2 - k / 2 + 4) % 4);
            check("scan_idle", {bus.an, bus.seg}, {~m, 7'b1111111});
            tick();
        end

        // ARMED shows dashes, GO shows ones
        go_idle();
        bus.start = 1;
        tick(); tick();
        capture(disp);
        check("armed_dash", disp, exp_fill(7'b1111110));
        bus.random_finish = 1;
        tick();
        bus.random_finish = 0;
        tick();
        capture(disp);
        check("go_ones", disp, exp_fill(7'b1001111));

        // Directed table
        foreach (vecs[i]) begin
            run(vecs[i].t, vecs[i].mode, 1'b1, busy_n, nb_n, disp);
            model(vecs[i].t, vecs[i].mode, fail, shown, nb);
            check($sformatf("vec%0d_busy", i), busy_n, vecs[i].exp_fail ? 0 : 32);
            check($sformatf("vec%0d_newbest", i), nb_n, vecs[i].exp_nb);
            check($sformatf("vec%0d_display", i), disp,
                  vecs[i].exp_fail ? exp_fail_pic() : exp_number(vecs[i].exp_shown));
        end

        // Best time in IDLE
        go_idle();
        bus.show_best = 1;
        tick(); tick();
        capture(disp);
        check("idle_best", disp, exp_number(m_best));
        bus.show_best = 0;
        tick(); tick();
        capture(disp);
        check("idle_blank", disp, exp_fill(7'b1111111));

        // start=0 mid-conversion: abort with best unchanged
        go_idle();
        bus.start = 1; tick();
        bus.random_finish = 1; tick(); bus.random_finish = 0;
        bus.t_react = 32'd150; bus.react = 1; tick(); bus.react = 0;
        for (int i = 0; i < 5; i++) tick();
        check("abort_busy", bus.busy, 1'b1);
        bus.start = 0; bus.show_best = 1;
        nb_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.new_best) nb_n++;
            tick();
        end
        check("abort_no_pulse", nb_n, 0);
        capture(disp);
        check("abort_best_kept", disp, exp_number(m_best));

        // Reset mid-conversion: best cleared
        go_idle();
        bus.start = 1; tick();
        bus.random_finish = 1; tick(); bus.random_finish = 0;
        bus.t_react = 32'd12345; bus.react = 1; tick(); bus.react = 0;
        for (int i = 0; i < 7; i++) tick();
        reset = 0;
        tick();
        check("reset_conv", {bus.busy, bus.an, bus.seg}, {1'b0, 4'b1111, 7'b1111111});
        reset = 1;
        m_valid = 0; m_best = 0;
        bus.start = 0; bus.show_best = 1;
        tick(); tick();
        capture(disp);
        check("reset_best_cleared", disp, exp_fill(7'b1111111));

        // Randomized attempts against the model
        for (int i = 0; i < 14; i++) begin
            t = $urandom_range(20000, 50);
            r = $urandom_range(9, 0);
            mode = (r < 7) ? 0 : ((r == 7) ? 1 : 2);
            run(t, mode, 1'($urandom_range(1, 0)), busy_n, nb_n, disp);
            model(t, mode, fail, shown, nb);
            exp_busy = fail ? 0 : 32;
            check($sformatf("rnd%0d_busy t=%0d", i, t), busy_n, exp_busy);
            check($sformatf("rnd%0d_newbest t=%0d", i, t), nb_n, nb);
            check($sformatf("rnd%0d_display t=%0d", i, t), disp,
                  fail ? exp_fail_pic() : exp_number(shown));
        end

        go_idle();
        bus.show_best = 1;
        tick(); tick();
        capture(disp);
        check("final_best", disp, m_valid ? exp_number(m_best) : exp_fill(7'b1111111));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
